// File: rtl/pll_reset_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_reset_sequencer_pkg: state encodings and shared widths. Rev 1.0
// ---------------------------------------------------------------------------
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_REL    = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  localparam int LOCK_LOSS_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_2ff: two-flop synchroniser with synchronous clear. Rev 1.0
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pll_reset_sequencer: PLL reset/lock supervision and staggered domain reset release. Rev 1.0
// ---------------------------------------------------------------------------
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int NUM_DOMAINS         = 3,
  parameter int DOMAIN_STAGGER      = 8
) (
  input  logic                   i_refclk,
  input  logic                   i_rst,
  input  logic                   i_pll_locked,
  input  logic                   i_relock_req,
  output logic                   o_pll_rst,
  output logic [NUM_DOMAINS-1:0] o_domain_rst,
  output logic                   o_ready,
  output logic                   o_timeout_err,
  output logic [LOCK_LOSS_W-1:0] o_lock_loss_cnt
);

  // The single counter must reach the last value of every timed state.
  localparam int c_rel_span = (NUM_DOMAINS - 1) * DOMAIN_STAGGER;
  localparam int c_cnt_max  = max2(max2(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                                   max2(LOCK_STABLE_CYCLES, c_rel_span + 1));
  localparam int c_cnt_w    = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(RST_HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rel_last     = c_cnt_w'(c_rel_span);

  state_t                 r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_domain_rst;
  logic                   r_ready;
  logic                   r_timeout_err;
  logic [LOCK_LOSS_W-1:0] r_lock_loss_cnt;

  logic                   w_lock_s;
  logic [NUM_DOMAINS-1:0] w_rel_hit;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lock_s)
  );

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rel_hit
    assign w_rel_hit[gi] = (r_cnt == c_cnt_w'(gi * DOMAIN_STAGGER));
  end

  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state         <= S_RESET;
      r_cnt           <= '0;
      r_pll_rst       <= 1'b1;
      r_domain_rst    <= '1;
      r_ready         <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_cnt == c_hold_last) begin
            r_state   <= S_WAIT;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (w_lock_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_timeout_last) begin
            r_state       <= S_RESET;
            r_cnt         <= '0;
            r_pll_rst     <= 1'b1;
            r_timeout_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STABLE: begin
          if (!w_lock_s) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else if (r_cnt == c_stable_last) begin
            r_state <= S_REL;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_REL: begin
          // A drop during release is a failed bring-up, not a lock loss.
          if (!w_lock_s) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_domain_rst <= '1;
          end else begin
            r_domain_rst <= r_domain_rst & ~w_rel_hit;
            if (r_cnt == c_rel_last) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
              r_ready <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (!w_lock_s || i_relock_req) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_domain_rst <= '1;
            r_ready      <= 1'b0;
            if (!w_lock_s && (r_lock_loss_cnt != '1)) begin
              r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state      <= S_RESET;
          r_cnt        <= '0;
          r_pll_rst    <= 1'b1;
          r_domain_rst <= '1;
          r_ready      <= 1'b0;
        end
      endcase
    end
  end

  assign o_pll_rst       = r_pll_rst;
  assign o_domain_rst    = r_domain_rst;
  assign o_ready         = r_ready;
  assign o_timeout_err   = r_timeout_err;
  assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer: vector-table and scoreboard bench for the sequencer. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       lk;
  logic       rq;
  logic       o_pll_rst;
  logic [2:0] o_domain_rst;
  logic       o_ready;
  logic       o_timeout_err;
  logic [7:0] o_lock_loss_cnt;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .NUM_DOMAINS         (3),
    .DOMAIN_STAGGER      (2)
  ) dut (
    .i_refclk        (clk),
    .i_rst           (rst),
    .i_pll_locked    (lk),
    .i_relock_req    (rq),
    .o_pll_rst       (o_pll_rst),
    .o_domain_rst    (o_domain_rst),
    .o_ready         (o_ready),
    .o_timeout_err   (o_timeout_err),
    .o_lock_loss_cnt (o_lock_loss_cnt)
  );

  typedef struct packed {
    logic       pll;
    logic [2:0] dom;
    logic       rdy;
    logic       terr;
    logic [7:0] llc;
  } out_t;

  typedef struct {
    logic rst;
    logic lk;
    logic rq;
    int   n;
    out_t exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(int r, int l, int q, int n, int p, int d, int y, int t, int c);
    vec_t v;
    v.rst      = r[0];
    v.lk       = l[0];
    v.rq       = q[0];
    v.n        = n;
    v.exp.pll  = p[0];
    v.exp.dom  = 3'(d);
    v.exp.rdy  = y[0];
    v.exp.terr = t[0];
    v.exp.llc  = 8'(c);
    tbl.push_back(v);
  endfunction

  // Rows common to every bring-up once lock_s is already high when S_WAIT is entered.
  function automatic void add_tail(int nrun, int t, int c);
    add(0, 1, 0, 10,   0, 3'b111, 0, t, c);
    add(0, 1, 0, 2,    0, 3'b110, 0, t, c);
    add(0, 1, 0, 2,    0, 3'b100, 0, t, c);
    add(0, 1, 0, nrun, 0, 3'b000, 1, t, c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_sb(input string nm);
    out_t e;
    out_t a;
    e = sb.pop_front();
    a = {o_pll_rst, o_domain_rst, o_ready, o_timeout_err, o_lock_loss_cnt};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got pll=%b dom=%b rdy=%b terr=%b llc=%0d, want pll=%b dom=%b rdy=%b terr=%b llc=%0d",
               nm, a.pll, a.dom, a.rdy, a.terr, a.llc, e.pll, e.dom, e.rdy, e.terr, e.llc);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst = tbl[i].rst;
        lk  = tbl[i].lk;
        rq  = tbl[i].rq;
        sb.push_back(tbl[i].exp);
        step();
        check_sb($sformatf("%s[%0d.%0d]", tag, i, k));
      end
    end
    tbl.delete();
    rst = 1'b0;
    rq  = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int bound);
    int i;
    i = 0;
    while (!o_ready && i < bound) begin
      step();
      i++;
    end
    chk(nm, int'(o_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lk  = 1'b1;
    rq  = 1'b0;

    // Power-up with lock tied high.
    add(1, 1, 0, 3, 1, 3'b111, 0, 0, 0);
    add(0, 1, 0, 3, 1, 3'b111, 0, 0, 0);
    add_tail(4, 0, 0);
    run_table("powerup");

    // Lock drop in RUN for 3 cycles.
    add(0, 0, 0, 2, 0, 3'b000, 1, 0, 0);
    add(0, 0, 0, 1, 1, 3'b111, 0, 0, 1);
    add(0, 1, 0, 3, 1, 3'b111, 0, 0, 1);
    add_tail(3, 0, 1);
    run_table("lockloss");

    // Software relock: no count.
    add(0, 1, 1, 1, 1, 3'b111, 0, 0, 1);
    add(0, 1, 0, 3, 1, 3'b111, 0, 0, 1);
    add_tail(3, 0, 1);
    run_table("relock");

    // Relock coinciding with the observed lock drop: exactly one increment.
    add(0, 0, 0, 2, 0, 3'b000, 1, 0, 1);
    add(0, 0, 1, 1, 1, 3'b111, 0, 0, 2);
    add(0, 1, 0, 3, 1, 3'b111, 0, 0, 2);
    add_tail(3, 0, 2);
    run_table("both");

    // Lock drop during release: back to reset, count unchanged.
    add(0, 1, 1, 1,  1, 3'b111, 0, 0, 2);
    add(0, 1, 0, 3,  1, 3'b111, 0, 0, 2);
    add(0, 1, 0, 10, 0, 3'b111, 0, 0, 2);
    add(0, 1, 0, 1,  0, 3'b110, 0, 0, 2);
    add(0, 0, 0, 1,  0, 3'b110, 0, 0, 2);
    add(0, 0, 0, 1,  0, 3'b100, 0, 0, 2);
    add(0, 0, 0, 1,  1, 3'b111, 0, 0, 2);
    add(0, 1, 0, 3,  1, 3'b111, 0, 0, 2);
    add_tail(3, 0, 2);
    run_table("relloss");

    // Timeout with relock ignored in S_WAIT, then recovery; error stays sticky.
    add(1, 0, 0, 3,  1, 3'b111, 0, 0, 0);
    add(0, 0, 0, 3,  1, 3'b111, 0, 0, 0);
    add(0, 0, 0, 1,  0, 3'b111, 0, 0, 0);
    add(0, 0, 1, 1,  0, 3'b111, 0, 0, 0);
    add(0, 0, 0, 30, 0, 3'b111, 0, 0, 0);
    add(0, 0, 0, 1,  1, 3'b111, 0, 1, 0);
    add(0, 1, 0, 3,  1, 3'b111, 0, 1, 0);
    add_tail(3, 1, 0);
    run_table("timeout");

    // One-cycle glitch at stable count 5 restarts the stable window.
    add(1, 1, 0, 3,  1, 3'b111, 0, 0, 0);
    add(0, 1, 0, 3,  1, 3'b111, 0, 0, 0);
    add(0, 1, 0, 5,  0, 3'b111, 0, 0, 0);
    add(0, 0, 0, 1,  0, 3'b111, 0, 0, 0);
    add(0, 1, 0, 11, 0, 3'b111, 0, 0, 0);
    add(0, 1, 0, 2,  0, 3'b110, 0, 0, 0);
    add(0, 1, 0, 2,  0, 3'b100, 0, 0, 0);
    add(0, 1, 0, 3,  0, 3'b000, 1, 0, 0);
    run_table("glitch");

    // Saturation of the lock-loss counter, starting from a fresh reset with a timeout.
    rst = 1'b1;
    lk  = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (40) step();
    chk("terr_set", int'(o_timeout_err), 1);
    lk = 1'b1;
    wait_ready("bringup_after_timeout", 60);

    for (int k = 1; k <= 300; k++) begin
      lk = 1'b0;
      step();
      step();
      step();
      chk($sformatf("llc_loss%0d", k), int'(o_lock_loss_cnt), (k > 255) ? 255 : k);
      lk = 1'b1;
      wait_ready($sformatf("ready_loss%0d", k), 100);
    end
    chk("llc_saturated", int'(o_lock_loss_cnt), 255);

    // Reset in the middle of S_REL.
    rq = 1'b1;
    step();
    rq = 1'b0;
    for (int i = 0; i < 50 && o_domain_rst != 3'b110; i++) step();
    chk("reached_rel", int'(o_domain_rst), 3'b110);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrel_pll_rst", int'(o_pll_rst), 1);
    chk("midrel_domain_rst", int'(o_domain_rst), 3'b111);
    chk("midrel_ready", int'(o_ready), 0);
    chk("midrel_timeout_err", int'(o_timeout_err), 0);
    chk("midrel_llc", int'(o_lock_loss_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
